// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter sharing one memory port between fetch and data.
// Alternates grants under contention and counts contention cycles.
module mem_port_arbiter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             imem_read,
    input  logic [31:0]      imem_address,
    output logic [31:0]      imem_rdata,
    output logic             imem_resp,
    input  logic             dmem_read,
    input  logic             dmem_write,
    input  logic [31:0]      dmem_address,
    input  logic [31:0]      dmem_wdata,
    input  logic [3:0]       dmem_byte_enable,
    output logic [31:0]      dmem_rdata,
    output logic             dmem_resp,
    output logic             pmem_read,
    output logic             pmem_write,
    output logic [31:0]      pmem_address,
    output logic [31:0]      pmem_wdata,
    output logic [3:0]       pmem_byte_enable,
    input  logic [31:0]      pmem_rdata,
    input  logic             pmem_resp,
    output logic [CNT_W-1:0] arb_conflicts
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] SERVE_I = 2'd1;
    localparam logic [1:0] SERVE_D = 2'd2;

    logic [1:0]  state;
    logic        last_grant_d;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        req_write;

    logic d_pend;
    logic i_pend;
    logic conflict;
    logic grant_d;
    logic grant_i;
    logic serving;

    always_comb begin
        d_pend   = dmem_read | dmem_write;
        i_pend   = imem_read;
        conflict = (state == IDLE) & d_pend & i_pend;
        // Data wins unless fetch is also pending and data took the last grant
        grant_d  = d_pend & (~i_pend | ~last_grant_d);
        grant_i  = i_pend & ~grant_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            last_grant_d  <= 1'b0;
            req_addr      <= '0;
            req_wdata     <= '0;
            req_be        <= '0;
            req_write     <= 1'b0;
            arb_conflicts <= '0;
        end else begin
            if (conflict && !(&arb_conflicts))
                arb_conflicts <= arb_conflicts + CNT_W'(1);
            unique case (state)
                IDLE: begin
                    if (grant_d) begin
                        state        <= SERVE_D;
                        last_grant_d <= 1'b1;
                        req_addr     <= dmem_address & 32'hFFFF_FFFC;
                        req_wdata    <= dmem_wdata;
                        req_be       <= dmem_write ? dmem_byte_enable : 4'b1111;
                        req_write    <= dmem_write;
                    end else if (grant_i) begin
                        state        <= SERVE_I;
                        last_grant_d <= 1'b0;
                        req_addr     <= imem_address & 32'hFFFF_FFFC;
                        req_wdata    <= '0;
                        req_be       <= 4'b1111;
                        req_write    <= 1'b0;
                    end
                end
                SERVE_I, SERVE_D: begin
                    if (pmem_resp)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        serving          = (state == SERVE_I) | (state == SERVE_D);
        pmem_read        = serving & ~req_write;
        pmem_write       = serving & req_write;
        pmem_address     = req_addr;
        pmem_wdata       = req_wdata;
        pmem_byte_enable = req_be;
        imem_resp        = (state == SERVE_I) & pmem_resp;
        dmem_resp        = (state == SERVE_D) & pmem_resp;
        imem_rdata       = imem_resp ? pmem_rdata : '0;
        dmem_rdata       = dmem_resp ? pmem_rdata : '0;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized scoreboard bench for mem_port_arbiter with a transaction-level
// reference model of requesters, arbitration and memory.
module tb_mem_port_arbiter;

    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          imem_read;
    logic [31:0]   imem_address;
    logic [31:0]   imem_rdata;
    logic          imem_resp;
    logic          dmem_read;
    logic          dmem_write;
    logic [31:0]   dmem_address;
    logic [31:0]   dmem_wdata;
    logic [3:0]    dmem_byte_enable;
    logic [31:0]   dmem_rdata;
    logic          dmem_resp;
    logic          pmem_read;
    logic          pmem_write;
    logic [31:0]   pmem_address;
    logic [31:0]   pmem_wdata;
    logic [3:0]    pmem_byte_enable;
    logic [31:0]   pmem_rdata;
    logic          pmem_resp;
    logic [CW-1:0] arb_conflicts;

    always #5 clk = ~clk;

    mem_port_arbiter #(.CNT_W(CW)) dut (
        .clk              (clk),
        .rst              (rst),
        .imem_read        (imem_read),
        .imem_address     (imem_address),
        .imem_rdata       (imem_rdata),
        .imem_resp        (imem_resp),
        .dmem_read        (dmem_read),
        .dmem_write       (dmem_write),
        .dmem_address     (dmem_address),
        .dmem_wdata       (dmem_wdata),
        .dmem_byte_enable (dmem_byte_enable),
        .dmem_rdata       (dmem_rdata),
        .dmem_resp        (dmem_resp),
        .pmem_read        (pmem_read),
        .pmem_write       (pmem_write),
        .pmem_address     (pmem_address),
        .pmem_wdata       (pmem_wdata),
        .pmem_byte_enable (pmem_byte_enable),
        .pmem_rdata       (pmem_rdata),
        .pmem_resp        (pmem_resp),
        .arb_conflicts    (arb_conflicts)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        dside;
        logic [31:0] rdata;
    } resp_t;

    resp_t sbq[$];

    // Monitor: every requester response must match the oldest memory completion
    always @(negedge clk) begin
        resp_t e;
        if (imem_resp || dmem_resp) begin
            chk("resp_onehot", {31'b0, imem_resp & dmem_resp}, 32'd0);
            if (sbq.size() == 0) begin
                chk("resp_unexpected", {30'b0, imem_resp, dmem_resp}, 32'd0);
            end else begin
                e = sbq.pop_front();
                chk("resp_owner", {31'b0, dmem_resp}, {31'b0, e.dside});
                chk("resp_rdata", e.dside ? dmem_rdata : imem_rdata, e.rdata);
                chk("other_rdata", e.dside ? imem_rdata : dmem_rdata, 32'd0);
            end
        end else begin
            if (sbq.size() != 0) begin
                void'(sbq.pop_front());
                chk("resp_present", {31'b0, imem_resp | dmem_resp}, 32'd1);
            end
            chk("idle_rdata", imem_rdata | dmem_rdata, 32'd0);
        end
    end

    logic        i_act, d_act;
    logic        m_busy, m_own, m_last;
    int          m_cnt;
    logic        e_wr;
    logic [31:0] e_addr, e_wd;
    logic [3:0]  e_be;
    int          dly;
    int          force_dly = -1;
    logic        own, dp, ip;
    int          op;

    task automatic step(input int p_req);
        @(posedge clk);
        #1;
        // Account for what the arbiter did at the edge just passed
        if (rst) begin
            m_busy = 1'b0;
            m_last = 1'b0;
            m_cnt  = 0;
        end else if (m_busy) begin
            if (pmem_resp) begin
                m_busy = 1'b0;
                if (m_own) d_act = 1'b0;
                else       i_act = 1'b0;
            end
        end else begin
            dp = d_act;
            ip = i_act;
            if (dp && ip && m_cnt < CMAX) m_cnt++;
            if (dp || ip) begin
                own    = dp && (!ip || !m_last);
                m_busy = 1'b1;
                m_own  = own;
                m_last = own;
                e_wr   = own && dmem_write;
                e_addr = (own ? dmem_address : imem_address) & 32'hFFFF_FFFC;
                e_be   = e_wr ? dmem_byte_enable : 4'hF;
                e_wd   = own ? dmem_wdata : 32'd0;
                dly    = (force_dly >= 0) ? force_dly : $urandom_range(0, 3);
            end
        end

        chk("pmem_read", {31'b0, pmem_read}, {31'b0, m_busy && !e_wr});
        chk("pmem_write", {31'b0, pmem_write}, {31'b0, m_busy && e_wr});
        if (m_busy) begin
            chk("pmem_address", pmem_address, e_addr);
            chk("pmem_be", {28'b0, pmem_byte_enable}, {28'b0, e_be});
            if (!m_own || e_wr) chk("pmem_wdata", pmem_wdata, e_wd);
        end
        chk("arb_conflicts", {28'b0, arb_conflicts}, m_cnt);

        pmem_resp  = 1'b0;
        pmem_rdata = $urandom;
        if (m_busy && !rst) begin
            if (dly == 0) begin
                pmem_resp = 1'b1;
                sbq.push_back('{m_own, pmem_rdata});
            end else begin
                dly--;
            end
        end

        // Granted request inputs are don't-care; scramble them
        if (m_busy && m_own && $urandom_range(0, 2) == 0) begin
            dmem_address = $urandom;
            dmem_wdata   = $urandom;
        end
        if (m_busy && !m_own && $urandom_range(0, 2) == 0)
            imem_address = $urandom;
        if (!i_act && $urandom_range(0, 99) < p_req) begin
            i_act        = 1'b1;
            imem_address = $urandom;
        end
        if (!d_act && $urandom_range(0, 99) < p_req) begin
            d_act            = 1'b1;
            op               = $urandom_range(0, 2);
            dmem_read        = (op != 1);
            dmem_write       = (op != 0);
            dmem_address     = $urandom;
            dmem_wdata       = $urandom;
            dmem_byte_enable = 4'($urandom);
        end
        imem_read = i_act;
        if (!d_act) begin
            dmem_read  = 1'b0;
            dmem_write = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1;
        imem_read = 0; imem_address = 0;
        dmem_read = 0; dmem_write = 0; dmem_address = 0;
        dmem_wdata = 0; dmem_byte_enable = 0;
        pmem_rdata = 0; pmem_resp = 0;
        i_act = 0; d_act = 0;
        m_busy = 0; m_own = 0; m_last = 0; m_cnt = 0;
        e_wr = 0; e_addr = 0; e_wd = 0; e_be = 0; dly = 0;
        step(0);
        step(0);
        chk("rst_addr", pmem_address, 32'd0);
        chk("rst_wdata", pmem_wdata, 32'd0);
        chk("rst_be", {28'b0, pmem_byte_enable}, 32'd0);
        chk("rst_resp", {30'b0, imem_resp, dmem_resp}, 32'd0);
        rst = 1'b0;

        // Single fetch to an unaligned address
        i_act = 1; imem_read = 1; imem_address = 32'h0000_0063;
        force_dly = 2;
        repeat (6) step(0);

        // Single byte-lane store
        d_act = 1; dmem_write = 1; dmem_read = 0;
        dmem_address = 32'h100; dmem_wdata = 32'h00AB_0000;
        dmem_byte_enable = 4'b0100;
        repeat (6) step(0);
        force_dly = -1;

        // Reset, then both sides contend continuously
        rst = 1'b1;
        step(0);
        rst = 1'b0;
        i_act = 1; imem_read = 1; imem_address = $urandom;
        d_act = 1; dmem_read = 1; dmem_write = 0;
        dmem_address = $urandom; dmem_byte_enable = 4'b0011;
        repeat (60) step(100);

        repeat (2000) step(50);
        repeat (10) step(0);

        // Reset while serving data with the memory stalled
        force_dly = 1000;
        d_act = 1; dmem_read = 1; dmem_write = 1;
        dmem_address = 32'h0000_0204; dmem_wdata = 32'h1234_5678;
        dmem_byte_enable = 4'b1001;
        step(0);
        step(0);
        chk("stall_write", {31'b0, pmem_write}, 32'd1);
        rst = 1'b1;
        i_act = 0; d_act = 0;
        step(0);
        rst = 1'b0;
        force_dly = -1;
        chk("rst_strobe", {30'b0, pmem_read, pmem_write}, 32'd0);
        chk("rst_cnt", {28'b0, arb_conflicts}, 32'd0);
        pmem_resp  = 1'b1;
        pmem_rdata = 32'hCAFE_F00D;
        step(0);
        step(0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

- Shares the single physical memory port between two requesters:
  - instruction fetch, read-only;
  - the data memory stage, read/write with byte enables.
- Sits between fetch/mem stages and main memory.
- Latches the winning request, drives the memory port from registered copies, and returns the response to the requester that owns the transaction.
- Alternates grants when both sides contend, and counts contention cycles for performance debug.

## Interface
Parameters:
- CNT_W, 16, width of the saturating contention counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- imem_read  input  1  fetch read request; held until imem_resp.
- imem_address  input  32  fetch address.
- imem_rdata  output  32  fetch read data; valid only while imem_resp=1.
- imem_resp  output  1  one-cycle completion pulse for fetch.
- dmem_read  input  1  data read request; held until dmem_resp.
- dmem_write  input  1  data write request; held until dmem_resp.
- dmem_address  input  32  data address (word-aligned by producer).
- dmem_wdata  input  32  store data, already lane-shifted.
- dmem_byte_enable  input  4  store lane enables.
- dmem_rdata  output  32  data read data; valid only while dmem_resp=1.
- dmem_resp  output  1  one-cycle completion pulse for data.
- pmem_read  output  1  memory read strobe.
- pmem_write  output  1  memory write strobe.
- pmem_address  output  32  memory address; bits [1:0] always 0.
- pmem_wdata  output  32  memory write data.
- pmem_byte_enable  output  4  memory lane enables.
- pmem_rdata  input  32  memory read data; valid with pmem_resp.
- pmem_resp  input  1  memory completion; high exactly one cycle per transaction.
- arb_conflicts  output  CNT_W  saturating count of contention cycles.

## Operation
State machine: IDLE, SERVE_I, SERVE_D.

- **IDLE**
  - Pending sets: D_pend = dmem_read|dmem_write; I_pend = imem_read.
  - Only D_pend: go to SERVE_D. Only I_pend: go to SERVE_I.
  - Both pending: grant the side opposite last_grant; arb_conflicts increments this cycle, saturating at all-ones.
  - On any grant, capture into request registers:
    - address, with [1:0] forced to 00;
    - wdata and byte_enable;
    - op type: write if dmem_write, else read. dmem_read and dmem_write both high is treated as a write.
  - Update last_grant on the same edge.
- **Request register contents**
  - Fetch grants: op=read, byte_enable=4'b1111, wdata=0.
  - Data reads: byte_enable=4'b1111, ignoring dmem_byte_enable.
- **SERVE_I / SERVE_D**
  - pmem_read or pmem_write driven from the registered op; never both.
  - address, wdata and byte_enable come from the registers and stay stable until pmem_resp.
  - Requester inputs are ignored while in these states.
  - On pmem_resp:
    - the owning side's resp=1 and its rdata=pmem_rdata, combinationally in that cycle;
    - the other side's resp stays 0;
    - next state is IDLE.
- **Outside SERVE states:** all pmem strobes are 0; imem_resp=dmem_resp=0; rdata outputs are 0.
- **Reset values:**
  - state=IDLE; last_grant=I, so data wins the first conflict.
  - Request registers are 0, so pmem_address, pmem_wdata and pmem_byte_enable read 0.
  - arb_conflicts=0; pmem strobes and resp outputs are 0.
- **rst asserted in a SERVE state:** return to IDLE; all strobes drop on the following cycle; the transaction is abandoned and no resp is issued. A pmem_resp arriving in IDLE is ignored.

## Timing
- Request first visible in IDLE at cycle N: pmem strobe is high from N+1 through the cycle of pmem_resp.
- Minimum latency: pmem_resp at N+1 gives requester resp at N+1, i.e. 2 cycles request-to-resp.
- Response arrives k cycles after the strobe: requester resp at N+1+k.
- After resp the arbiter spends at least one cycle in IDLE; maximum throughput is one transaction per 2 cycles.
- Fairness under continuous contention: grants strictly alternate D, I, D, I… Neither side waits more than one transaction behind the other.
- The requester drops or changes its request on the edge after its resp. A request that is still high in the IDLE cycle after resp is treated as a new request.

## Test plan
- Reset then single fetch: imem_read=1, imem_address=0x0000_0063 -> pmem_read=1 with pmem_address=0x0000_0060 next cycle, pmem_byte_enable=1111. pmem_resp with rdata=0xDEAD_BEEF after 3 cycles -> imem_resp=1 and imem_rdata=0xDEAD_BEEF in that same cycle; dmem_resp=0.
- Store: dmem_write=1, address 0x100, wdata=0x00AB_0000, byte_enable=0100 -> pmem_write=1, pmem_read=0, pmem_wdata=0x00AB_0000, pmem_byte_enable=0100, held stable until pmem_resp -> dmem_resp pulse.
- Simultaneous first requests after reset: D granted first and I second. arb_conflicts=1 after the first IDLE cycle and 2 after the second IDLE cycle, where I is still waiting. No third grant to D while I is pending.
- Sustained contention for 8 transactions -> grant order D,I,D,I,D,I,D,I; each pmem_resp routed to exactly one resp output.
- dmem_read=dmem_write=1 -> pmem_write=1, pmem_read=0. Change dmem_address mid-transaction -> pmem_address unchanged.
- Assert rst while in SERVE_D with no pmem_resp -> next cycle pmem strobes=0, state IDLE, arb_conflicts=0. A late pmem_resp produces no dmem_resp.
